if_id_pip: RTL and testbench
============================

// Module: if_id_pip
// PURPOSE
//  IF/ID pipeline register for the pipelined MIPS core. Captures the fetched PC/instruction
//  pair from the PC + instruction-memory fetch stage and presents it to decode. Holds one
//  skid entry so the fetch already in flight when the hazard unit raises StallD is not lost.
//  FlushD (taken branch/jump) squashes both the register and the skid entry.
// PARAMETERS
//  WL        32   data/address width (PC, instruction)
//  NOP_WORD  0    instruction word driven on bubbles (sll $0,$0,0)
//  CNT_W     16   width of perf counters (only with IF_ID_PERF_CNT_EN)
// PORTS
//  CLK        in   1       clock, rising edge
//  RSTn       in   1       reset, asynchronous, active-low
//  PC_F       in   WL      PC of the fetched instruction
//  Instr_F    in   WL      instruction word from instruction memory
//  valid_F    in   1       PC_F/Instr_F carry a real fetch this cycle
//  ready_F    out  1       stage can accept a fetch; fetch stage must not advance PC when low
//  StallD     in   1       hazard unit: hold decode contents
//  FlushD     in   1       hazard unit: squash IF/ID contents
//  PC_D       out  WL      PC of instruction in decode
//  PCPlus4_D  out  WL      PC_D + 4
//  Instr_D    out  WL      instruction in decode (NOP_WORD when invalid)
//  valid_D    out  1       Instr_D is a real instruction
//  stall_cnt  out  CNT_W   cycles with StallD=1 (only with IF_ID_PERF_CNT_EN)
//  flush_cnt  out  CNT_W   cycles with FlushD=1 (only with IF_ID_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset (RSTn=0, async): PC_D=0, PCPlus4_D=4, Instr_D=NOP_WORD, valid_D=0, skid empty,
//    ready_F=1, counters=0. Deassertion takes effect at the next rising CLK.
//  - State: decode reg {PC,Instr,valid} + skid {sk_pc,sk_instr,sk_valid}. ready_F = !sk_valid
//    (registered; no combinational path from StallD to ready_F).
//  - Priority per rising edge: FlushD > StallD > normal advance.
//  - FlushD=1: valid_D<=0, Instr_D<=NOP_WORD, sk_valid<=0; incoming fetch dropped; PC_D holds.
//  - StallD=1, FlushD=0: decode reg holds; if valid_F&&ready_F, skid<=fetch, sk_valid<=1.
//  - Advance, sk_valid=1: decode reg<=skid, valid_D<=1, sk_valid<=0.
//  - Advance, sk_valid=0: PC_D<=PC_F, Instr_D<=valid_F?Instr_F:NOP_WORD, valid_D<=valid_F.
//  - Latency: fetch to decode 1 cycle when unstalled; +1 per stall cycle when skid used.
//  - PCPlus4_D registered as PC_F+4 (or sk_pc+4), modulo 2^WL: PC 32'hFFFF_FFFC -> 0.
//  - valid_F while ready_F=0 is a protocol violation: word ignored, sim assertion fires.
//  - Skid never overflows: while full ready_F=0 and the fetch stage holds.
// CONFIGURATION
//  IF_ID_PERF_CNT_EN defined: stall_cnt/flush_cnt ports exist; each increments on every
//   rising edge with its input high, saturating at all-ones; cleared on reset only.
//  Not defined: ports and counter flops absent; all other behaviour identical.
// STRUCTURE
//  Shared package mips_pip_pkg: WL, NOP_WORD constant, typedef if_id_t {pc,pcplus4,instr,valid}.
//  One sub-module: if_id_skid (single-entry holding register with load/clear, valid flag);
//  top holds decode reg, priority muxing, ready_F and optional counters.
// TESTING
//  1 Reset mid-run: RSTn low with valid_D=1, sk_valid=1 -> same cycle valid_D=0, Instr_D=0, ready_F=1.
//  2 Stream PC 0,4,8 with Instr 0x20080005.. -> PC_D follows 1 cycle later, PCPlus4_D=PC_D+4.
//  3 StallD 1 cycle while PC 8 in flight -> PC_D holds 4, ready_F=0 next cycle, PC 8 emerges
//    from skid after release, no fetch lost or duplicated.
//  4 FlushD and StallD together with skid full -> valid_D=0, Instr_D=NOP, ready_F=1 next cycle.
//  5 PC_F=32'hFFFF_FFFC -> PCPlus4_D=0; valid_F=0 unstalled -> valid_D=0, Instr_D=NOP.
//  6 IF_ID_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=4'hF; 3 flush cycles -> flush_cnt=3.

Source files
------------

// File: rtl/mips_pip_pkg.sv
// Shared definitions for the pipelined MIPS core: datapath width, bubble word,
// the IF/ID payload record and the PC increment helper.
package mips_pip_pkg;

    localparam int WL = 32;
    localparam logic [WL-1:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [WL-1:0] pc;
        logic [WL-1:0] pcplus4;
        logic [WL-1:0] instr;
        logic          valid;
    } if_id_t;

    // Wraps modulo 2^WL, so the last word of the address space rolls over to 0.
    function automatic logic [WL-1:0] pc_plus4(input logic [WL-1:0] pc);
        return pc + 32'd4;
    endfunction

    localparam if_id_t IF_ID_RST = '{pc: 32'h0000_0000, pcplus4: 32'h0000_0004,
                                     instr: NOP_WORD, valid: 1'b0};

endpackage

// File: rtl/if_id_pip_chk.sv
// Protocol checker for the fetch handshake: a fetch must never be offered while ready_F is low.
module if_id_pip_chk (
    input logic CLK,
    input logic RSTn,
    input logic valid_F,
    input logic ready_F
);

    a_no_fetch_when_full: assert property (@(posedge CLK) disable iff (!RSTn)
        !(valid_F && !ready_F));

endmodule

// File: rtl/if_id_skid.sv
// Single-entry holding register for a fetch that arrives while decode is stalled.
// Clear dominates load.
module if_id_skid
    import mips_pip_pkg::*;
#(
    parameter int WL_P = WL
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clr,
    input  logic [WL_P-1:0] pc_in,
    input  logic [WL_P-1:0] instr_in,
    output logic [WL_P-1:0] sk_pc,
    output logic [WL_P-1:0] sk_instr,
    output logic            sk_valid
);

    logic [WL_P-1:0] pc_q, pc_d;
    logic [WL_P-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    // Next-state selection for the holding entry.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= {WL_P{1'b0}};
            instr_q <= {WL_P{1'b0}};
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign sk_pc    = pc_q;
    assign sk_instr = instr_q;
    assign sk_valid = valid_q;

endmodule

// File: rtl/if_id_pip.sv
// IF/ID pipeline register with one skid entry; flush > stall > advance.
// Optional stall/flush performance counters under IF_ID_PERF_CNT_EN.
module if_id_pip
    import mips_pip_pkg::*;
#(
    parameter int            WL       = mips_pip_pkg::WL,
    parameter logic [WL-1:0] NOP_WORD = mips_pip_pkg::NOP_WORD,
    parameter int            CNT_W    = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [WL-1:0] PC_F,
    input  logic [WL-1:0] Instr_F,
    input  logic          valid_F,
    output logic          ready_F,
    input  logic          StallD,
    input  logic          FlushD,
    output logic [WL-1:0] PC_D,
    output logic [WL-1:0] PCPlus4_D,
    output logic [WL-1:0] Instr_D,
    output logic          valid_D
`ifdef IF_ID_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
   ,output logic [CNT_W-1:0] flush_cnt
`endif
);

    if_id_t        dec_q, dec_d;
    logic          ready_q, ready_d;
    logic          sk_load, sk_clr, sk_valid;
    logic [WL-1:0] sk_pc, sk_instr;

    // The skid only captures the fetch that was already in flight when the stall hit.
    assign sk_load = !FlushD && StallD && valid_F && ready_q;
    assign sk_clr  = FlushD || (!StallD && sk_valid);

    if_id_skid #(.WL_P(WL)) u_skid (
        .clk      (CLK),
        .rst_n    (RSTn),
        .load     (sk_load),
        .clr      (sk_clr),
        .pc_in    (PC_F),
        .instr_in (Instr_F),
        .sk_pc    (sk_pc),
        .sk_instr (sk_instr),
        .sk_valid (sk_valid)
    );

    // Decode register priority mux and next skid-empty indication.
    always_comb begin
        dec_d = dec_q;
        if (FlushD) begin
            dec_d.valid = 1'b0;
            dec_d.instr = NOP_WORD;
        end else if (StallD) begin
            dec_d = dec_q;
        end else if (sk_valid) begin
            dec_d = '{pc: sk_pc, pcplus4: pc_plus4(sk_pc), instr: sk_instr, valid: 1'b1};
        end else begin
            dec_d.pc      = PC_F;
            dec_d.pcplus4 = pc_plus4(PC_F);
            dec_d.instr   = valid_F ? Instr_F : NOP_WORD;
            dec_d.valid   = valid_F;
        end

        if (sk_clr) begin
            ready_d = 1'b1;
        end else if (sk_load) begin
            ready_d = 1'b0;
        end else begin
            ready_d = ready_q;
        end
    end

    // Decode register and registered ready.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dec_q   <= IF_ID_RST;
            ready_q <= 1'b1;
        end else begin
            dec_q   <= dec_d;
            ready_q <= ready_d;
        end
    end

    assign PC_D      = dec_q.pc;
    assign PCPlus4_D = dec_q.pcplus4;
    assign Instr_D   = dec_q.instr;
    assign valid_D   = dec_q.valid;
    assign ready_F   = ready_q;

    if_id_pip_chk u_chk (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .valid_F (valid_F),
        .ready_F (ready_q)
    );

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (FlushD && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter storage, cleared only by reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pip.sv
// Self-checking bench for if_id_pip: vector table through a scoreboard queue, plus
// hand-written reset-mid-run and (with IF_ID_PERF_CNT_EN) counter sequences.
module tb_if_id_pip;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] PC_F, Instr_F;
    logic        valid_F, StallD, FlushD;
    logic        ready_F, valid_D;
    logic [31:0] PC_D, PCPlus4_D, Instr_D;
`ifdef IF_ID_PERF_CNT_EN
    logic [3:0]  stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    if_id_pip #(.CNT_W(4)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .PC_F      (PC_F),
        .Instr_F   (Instr_F),
        .valid_F   (valid_F),
        .ready_F   (ready_F),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PC_D      (PC_D),
        .PCPlus4_D (PCPlus4_D),
        .Instr_D   (Instr_D),
        .valid_D   (valid_D)
`ifdef IF_ID_PERF_CNT_EN
       ,.stall_cnt (stall_cnt)
       ,.flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        st;
        logic        fl;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_instr;
        logic        e_v;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] instr;
        logic        v;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];

    localparam logic [31:0] I0 = 32'h2008_0005;
    localparam logic [31:0] I1 = 32'h2009_0006;
    localparam logic [31:0] I2 = 32'h200A_0007;
    localparam logic [31:0] I3 = 32'h200B_0008;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic st, input logic fl);
        valid_F = v;
        PC_F    = pc;
        Instr_F = instr;
        StallD  = st;
        FlushD  = fl;
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".PC_D"},      PC_D,      e.pc);
            chk({tag, ".PCPlus4_D"}, PCPlus4_D, e.p4);
            chk({tag, ".Instr_D"},   Instr_D,   e.instr);
            chk({tag, ".valid_D"},   {31'd0, valid_D}, {31'd0, e.v});
            chk({tag, ".ready_F"},   {31'd0, ready_F}, {31'd0, e.rdy});
        end
    endtask

    initial begin
        // stream, stall with skid, flush+stall with skid full, wrap, bubbles
        vecs[0]  = '{1'b1, 32'h0,         I0,            1'b0, 1'b0, 32'h0,         32'h4,   I0,    1'b1, 1'b1};
        vecs[1]  = '{1'b1, 32'h4,         I1,            1'b0, 1'b0, 32'h4,         32'h8,   I1,    1'b1, 1'b1};
        vecs[2]  = '{1'b1, 32'h8,         I2,            1'b1, 1'b0, 32'h4,         32'h8,   I1,    1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h8,         I2,            1'b0, 1'b0, 32'h8,         32'hC,   I2,    1'b1, 1'b1};
        vecs[4]  = '{1'b1, 32'hC,         I3,            1'b0, 1'b0, 32'hC,         32'h10,  I3,    1'b1, 1'b1};
        vecs[5]  = '{1'b1, 32'h10,        I0,            1'b1, 1'b0, 32'hC,         32'h10,  I3,    1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h10,        I0,            1'b1, 1'b1, 32'hC,         32'h10,  32'h0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFC, I1,            1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,   I1,    1'b1, 1'b1};
        vecs[8]  = '{1'b0, 32'h100,       32'hDEAD_BEEF, 1'b0, 1'b0, 32'h100,       32'h104, 32'h0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h200,       I2,            1'b0, 1'b1, 32'h100,       32'h104, 32'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h100,       32'h104, 32'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h300,       I3,            1'b1, 1'b0, 32'h100,       32'h104, 32'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h300,       I3,            1'b1, 1'b0, 32'h100,       32'h104, 32'h0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h300,       I3,            1'b0, 1'b0, 32'h300,       32'h304, I3,    1'b1, 1'b1};

        RSTn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        sb.push_back('{32'h0, 32'h4, 32'h0, 1'b0, 1'b1});
        compare_head("reset");

        @(negedge CLK);
        RSTn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].v, vecs[i].pc, vecs[i].instr, vecs[i].st, vecs[i].fl);
            sb.push_back('{vecs[i].e_pc, vecs[i].e_p4, vecs[i].e_instr, vecs[i].e_v, vecs[i].e_rdy});
            @(posedge CLK);
            #1;
            compare_head($sformatf("vec%0d", i));
        end

        // Fill the skid with decode valid, then reset asynchronously mid-cycle.
        @(negedge CLK);
        drive(1'b1, 32'h400, I0, 1'b1, 1'b0);
        @(posedge CLK);
        #1;
        chk("pre_rst.valid_D", {31'd0, valid_D}, 32'd1);
        chk("pre_rst.ready_F", {31'd0, ready_F}, 32'd0);
        #1;
        RSTn = 1'b0;
        #1;
        sb.push_back('{32'h0, 32'h4, 32'h0, 1'b0, 1'b1});
        compare_head("async_rst");
        @(negedge CLK);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        RSTn = 1'b1;
        sb.push_back('{32'h0, 32'h4, 32'h0, 1'b0, 1'b1});
        @(posedge CLK);
        #1;
        compare_head("post_rst");

`ifdef IF_ID_PERF_CNT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        @(negedge CLK);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_cnt", {28'd0, stall_cnt}, 32'hF);
        chk("flush_cnt", {28'd0, flush_cnt}, 32'h3);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
